// File: rtl/vga_draw_arbiter.sv
// N-source pixel arbiter feeding the VGA adapter write port; a grant is held until the source's last pixel.
// Define VGA_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module vga_draw_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int C_W     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC-1:0]         src_last,
    input  logic [NUM_SRC*X_W-1:0]     src_x,
    input  logic [NUM_SRC*Y_W-1:0]     src_y,
    input  logic [NUM_SRC*C_W-1:0]     src_color,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic [X_W-1:0]             x_out,
    output logic [Y_W-1:0]             y_out,
    output logic [C_W-1:0]             color_out,
    output logic                       plot,
    output logic                       busy,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       timeout_pulse
);
    localparam int ID_W  = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [C_W-1:0]   c_q, c_d;
    logic             plot_q, plot_d;
    logic             busy_q, busy_d;
    logic             tpulse_q, tpulse_d;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  next_ptr;
    logic             xfer;

`ifdef VGA_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) winner = ID_W'(i);
        end
    end

    assign next_ptr = '0;
`else
    // Round-robin: lowest valid index at or above the pointer, else lowest valid index overall (wrap).
    logic [ID_W-1:0] win_hi, win_lo;
    logic            has_hi;

    always_comb begin
        win_hi = '0;
        win_lo = '0;
        has_hi = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                win_lo = ID_W'(i);
                if (ID_W'(i) >= ptr_q) begin
                    win_hi = ID_W'(i);
                    has_hi = 1'b1;
                end
            end
        end
        winner = has_hi ? win_hi : win_lo;
    end

    assign next_ptr = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
`endif

    // NOTE: ready is gated by reset so an interrupted source cannot complete a handshake in the reset cycle.
    always_comb begin
        src_ready = '0;
        if (state_q == S_BURST && !reset) src_ready[grant_q] = 1'b1;
    end

    assign xfer = (state_q == S_BURST) && src_valid[grant_q];

    // NOTE: every *_d gets its hold/default value first, so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        c_d      = c_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        tpulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|src_valid) begin
                    state_d = S_BURST;
                    grant_d = winner;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_BURST: begin
                if (xfer) begin
                    x_d    = src_x[int'(grant_q)*X_W +: X_W];
                    y_d    = src_y[int'(grant_q)*Y_W +: Y_W];
                    c_d    = src_color[int'(grant_q)*C_W +: C_W];
                    plot_d = 1'b1;
                    cnt_d  = '0;
                    if (src_last[grant_q]) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        ptr_d   = next_ptr;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    ptr_d    = next_ptr;
                    cnt_d    = '0;
                    tpulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset takes priority over every update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            c_q      <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            c_q      <= c_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            tpulse_q <= tpulse_d;
        end
    end

    assign x_out         = x_q;
    assign y_out         = y_q;
    assign color_out     = c_q;
    assign plot          = plot_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;
    assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter: directed scenarios plus randomized bursts against a grant-owner model.
module tb_vga_draw_arbiter;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int TO = 4;
    localparam int PW = XW + YW + CW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  src_valid = '0;
    logic [N-1:0]  src_last  = '0;
    logic [N*XW-1:0] src_x     = '0;
    logic [N*YW-1:0] src_y     = '0;
    logic [N*CW-1:0] src_color = '0;
    logic [N-1:0]  src_ready;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic [CW-1:0] color_out;
    logic          plot, busy, timeout_pulse;
    logic [1:0]    grant_id;

    always #5 clock = ~clock;

    vga_draw_arbiter #(
        .NUM_SRC(N), .X_W(XW), .Y_W(YW), .C_W(CW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .src_valid(src_valid), .src_last(src_last),
        .src_x(src_x), .src_y(src_y), .src_color(src_color),
        .src_ready(src_ready),
        .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .plot(plot), .busy(busy), .grant_id(grant_id), .timeout_pulse(timeout_pulse)
    );

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        logic          last;
    } pix_t;

    // Per-source pixel FIFOs: a source presents its head pixel until it is accepted.
    pix_t fifo [N][256];
    int   head [N];
    int   tail [N];
    int   pct = 100;

    int n_checks = 0;
    int n_fail   = 0;
    int tp_seen  = 0;
    int plot_seen = 0;
    int glog[$];
    logic prev_busy = 1'b0;

    // Reference model: which source owns the port, plus round-robin pointer and idle run length.
    int          m_owner = -1;
    int          m_ptr   = 0;
    int          m_idle  = 0;
    int          m_grant = 0;
    logic        m_plot  = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_tp    = 1'b0;
    logic [PW-1:0] m_pix = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_pix(input int s, input int x, input int y, input int c, input bit last);
        pix_t p;
        p.x = XW'(x);
        p.y = YW'(y);
        p.c = CW'(c);
        p.last = last;
        fifo[s][tail[s] % 256] = p;
        tail[s]++;
    endtask

    task automatic push_burst(input int s, input int len);
        int x0 = int'($urandom_range(200));
        int y0 = int'($urandom_range(120));
        for (int k = 0; k < len; k++) push_pix(s, x0 + k, y0, int'($urandom_range(7)), k == len - 1);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_pick(input logic [N-1:0] v);
`ifdef VGA_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        if (m_owner >= 0 && !reset) return N'(1) << m_owner;
        return '0;
    endfunction

    task automatic m_release();
`ifdef VGA_ARB_FIXED_PRIO_EN
        m_ptr = 0;
`else
        m_ptr = (m_owner + 1) % N;
`endif
        m_owner = -1;
        m_busy  = 1'b0;
        m_idle  = 0;
    endtask

    // Called right after a rising edge; inputs still hold their pre-edge values.
    task automatic model_step();
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_idle = 0; m_grant = 0;
            m_plot = 1'b0; m_busy = 1'b0; m_tp = 1'b0; m_pix = '0;
        end else begin
            m_plot = 1'b0;
            m_tp   = 1'b0;
            if (m_owner < 0) begin
                if (src_valid != '0) begin
                    m_owner = m_pick(src_valid);
                    m_grant = m_owner;
                    m_busy  = 1'b1;
                    m_idle  = 0;
                end
            end else if (src_valid[m_owner]) begin
                m_plot = 1'b1;
                m_pix  = {src_x[m_owner*XW +: XW], src_y[m_owner*YW +: YW], src_color[m_owner*CW +: CW]};
                m_idle = 0;
                if (src_last[m_owner]) m_release();
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_tp = 1'b1;
                    m_release();
                end
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            pix_t p;
            logic v;
            p = (head[i] != tail[i]) ? fifo[i][head[i] % 256] : '0;
            v = (head[i] != tail[i]) && ($urandom_range(99) < pct);
            src_valid[i] = v;
            src_last[i]  = v ? p.last : 1'($urandom);
            src_x[i*XW +: XW]     = p.x;
            src_y[i*YW +: YW]     = p.y;
            src_color[i*CW +: CW] = p.c;
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        #1;
        check("src_ready", 32'(src_ready), 32'(m_ready()));
        acc = src_valid & src_ready;
        @(posedge clock);
        model_step();
        for (int i = 0; i < N; i++) if (acc[i]) head[i]++;
        #1;
        check("plot", 32'(plot), 32'(m_plot));
        check("pixel", 32'({x_out, y_out, color_out}), 32'(m_pix));
        check("busy", 32'(busy), 32'(m_busy));
        check("grant_id", 32'(grant_id), 32'(m_grant));
        check("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
        if (timeout_pulse) tp_seen++;
        if (plot) plot_seen++;
        if (busy && !prev_busy) glog.push_back(int'(grant_id));
        prev_busy = busy;
        drive();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(all_empty() && m_owner < 0) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(n < 400), 32'd1);
    endtask

    initial begin
        int exp_order[4];
        int n;
`ifdef VGA_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif

        // Reset held two cycles with every source requesting.
        for (int s = 0; s < N; s++) push_burst(s, 2);
        reset = 1'b1;
        drive();
        tick();
        tick();
        check("reset_ready", 32'(src_ready), 32'd0);
        glog.delete();
        reset = 1'b0;
        drive();
        drain("reset");
        check("reset_first_grant", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);

        // Single three-pixel burst from source 2.
        plot_seen = 0;
        push_pix(2, 10, 20, 3'b101, 1'b0);
        push_pix(2, 11, 20, 3'b101, 1'b0);
        push_pix(2, 12, 20, 3'b110, 1'b1);
        drive();
        drain("single");
        check("single_plots", 32'(plot_seen), 32'd3);

        // Sources 0 and 1 both continuously requesting 2-pixel bursts.
        glog.delete();
        push_burst(0, 2);
        push_burst(0, 2);
        push_burst(1, 2);
        push_burst(1, 2);
        drive();
        drain("contention");
        check("contention_grants", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("contention_order", 32'(i < glog.size() ? glog[i] : -1), 32'(exp_order[i]));

        // Reset on pixel 2 of a 5-pixel burst from source 1; source 2 queued behind it.
        push_burst(1, 5);
        drive();
        n = 0;
        while (tail[1] - head[1] > 4 && n < 50) begin
            tick();
            n++;
        end
        check("midreset_reached", 32'(tail[1] - head[1]), 32'd4);
        push_burst(2, 2);
        reset = 1'b1;
        drive();
        tick();
        check("midreset_plot", 32'(plot), 32'd0);
        glog.delete();
        reset = 1'b0;
        drive();
        drain("midreset");
        check("midreset_regrant", 32'(glog.size() > 0 ? glog[0] : -1), 32'd1);

        // Source 3 stalls after one pixel without last, then re-requests.
        tp_seen = 0;
        push_pix(3, 50, 60, 1, 1'b0);
        drive();
        drain("timeout");
        check("timeout_pulses", 32'(tp_seen), 32'd1);
        plot_seen = 0;
        push_pix(3, 51, 60, 2, 1'b1);
        drive();
        drain("rerequest");
        check("rerequest_plots", 32'(plot_seen), 32'd1);

        // Randomized traffic with gaps, stalls and occasional resets.
        pct = 70;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int s = 0; s < N; s++)
                if (head[s] == tail[s] && $urandom_range(3) == 0) push_burst(s, int'($urandom_range(1, 5)));
            reset = ($urandom_range(299) == 0);
            drive();
            tick();
        end
        reset = 1'b0;
        pct = 100;
        drive();
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
